// File: rtl/crypto_core_sequencer.sv
// crypto_core_sequencer: start/busy sequencer between the CW305 register block and
// NUM_CORES crypto cores. It accepts a start edge, waits a trigger delay, launches the
// selected core, times the run, captures the ciphertext and drives the scope trigger.
// It can repeat the operation back-to-back for trace averaging.
// Ports:
//   clk, rst_n                     crypto clock, synchronous active-low reset
//   start, core_sel, trig_dly      request edge, core index, launch delay
//   reps                           extra repetitions
//   core_busy, core_ct             per-core busy and ciphertext
//   core_start                     one-hot launch pulse
//   ct_out, cycles_out             result of the last completed op
//   busy, done, done_pulse         status
//   timeout_flag                   sticky abort flag
//   trigger                        scope trigger
module crypto_core_sequencer #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned CT_WIDTH  = 128,
  parameter int unsigned DLY_W     = 16,
  parameter int unsigned REP_W     = 8,
  parameter int unsigned CYC_W     = 32,
  parameter int unsigned TIMEOUT   = 2**20,
  localparam int unsigned SEL_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [SEL_W-1:0]              core_sel,
  input  logic [DLY_W-1:0]              trig_dly,
  input  logic [REP_W-1:0]              reps,
  input  logic [NUM_CORES-1:0]          core_busy,
  input  logic [NUM_CORES*CT_WIDTH-1:0] core_ct,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [CT_WIDTH-1:0]           ct_out,
  output logic [CYC_W-1:0]              cycles_out,
  output logic                          busy,
  output logic                          done,
  output logic                          done_pulse,
  output logic                          timeout_flag,
  output logic                          trigger
);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_LAUNCH, S_RUN, S_CAPTURE
  } state_e;

  state_e                 state_q, state_d;
  logic                   start_prev_q;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  logic [REP_W-1:0]       rep_q, rep_d;
  logic [DLY_W-1:0]       dcnt_q, dcnt_d;
  logic [CYC_W-1:0]       cnt_q, cnt_d;
  logic                   seen_q, seen_d;
  logic [NUM_CORES-1:0]   core_start_q, core_start_d;
  logic [CT_WIDTH-1:0]    ct_out_q, ct_out_d;
  logic [CYC_W-1:0]       cycles_q, cycles_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   done_pulse_q, done_pulse_d;
  logic                   timeout_q, timeout_d;
  logic                   trigger_q, trigger_d;

  logic [SEL_W-1:0]       sel_in_c;
  logic [SEL_W-1:0]       launch_sel_c;
  logic                   busy_sel_c;
  logic [CT_WIDTH-1:0]    ct_sel_c;
  logic [CYC_W-1:0]       cnt_inc_c;
  logic                   accept_c;

  // Out-of-range core index falls back to core 0
  assign sel_in_c  = (32'(core_sel) >= NUM_CORES) ? '0 : core_sel;
  assign cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CYC_W'(1);
  assign accept_c  = (state_q == S_IDLE) && start && !start_prev_q;

  // Selected core's busy and ciphertext
  always_comb begin
    busy_sel_c = 1'b0;
    ct_sel_c   = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (sel_q == SEL_W'(i)) begin
        busy_sel_c = core_busy[i];
        ct_sel_c   = core_ct[i*CT_WIDTH +: CT_WIDTH];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    dly_d        = dly_q;
    rep_d        = rep_q;
    dcnt_d       = dcnt_q;
    cnt_d        = cnt_q;
    seen_d       = seen_q;
    ct_out_d     = ct_out_q;
    cycles_d     = cycles_q;
    timeout_d    = timeout_q;
    done_pulse_d = 1'b0;
    launch_sel_c = sel_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          sel_d        = sel_in_c;
          dly_d        = trig_dly;
          rep_d        = reps;
          timeout_d    = 1'b0;
          launch_sel_c = sel_in_c;  // latch not yet visible on a zero-delay launch
          if (trig_dly == '0) begin
            state_d = S_LAUNCH;
          end else begin
            state_d = S_DELAY;
            dcnt_d  = trig_dly;
          end
        end
      end
      S_DELAY: begin
        if (dcnt_q == DLY_W'(1)) state_d = S_LAUNCH;
        else                      dcnt_d  = dcnt_q - DLY_W'(1);
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        seen_d  = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_inc_c;
        if (busy_sel_c) seen_d = 1'b1;
        // Second term covers cores whose busy never rises
        if ((seen_q && !busy_sel_c) ||
            (!seen_q && !busy_sel_c && cnt_inc_c == CYC_W'(2))) begin
          state_d = S_CAPTURE;
        end else if (cnt_inc_c == CYC_W'(TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_CAPTURE: begin
        ct_out_d = ct_sel_c;
        cycles_d = cnt_q;
        if (rep_q != '0) begin
          rep_d = rep_q - REP_W'(1);
          if (dly_q == '0) begin
            state_d = S_LAUNCH;
          end else begin
            state_d = S_DELAY;
            dcnt_d  = dly_q;
          end
        end else begin
          done_pulse_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs registered so they line up with the state they describe
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      core_start_d[i] = (state_d == S_LAUNCH) && (launch_sel_c == SEL_W'(i));
    end
    trigger_d = (state_d == S_LAUNCH) || (state_d == S_RUN);
    busy_d    = (state_d != S_IDLE);
    done_d    = !busy_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      sel_q        <= '0;
      dly_q        <= '0;
      rep_q        <= '0;
      dcnt_q       <= '0;
      cnt_q        <= '0;
      seen_q       <= 1'b0;
      core_start_q <= '0;
      ct_out_q     <= '0;
      cycles_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b1;
      done_pulse_q <= 1'b0;
      timeout_q    <= 1'b0;
      trigger_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start;
      sel_q        <= sel_d;
      dly_q        <= dly_d;
      rep_q        <= rep_d;
      dcnt_q       <= dcnt_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      core_start_q <= core_start_d;
      ct_out_q     <= ct_out_d;
      cycles_q     <= cycles_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      timeout_q    <= timeout_d;
      trigger_q    <= trigger_d;
    end
  end

  assign core_start   = core_start_q;
  assign ct_out       = ct_out_q;
  assign cycles_out   = cycles_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign done_pulse   = done_pulse_q;
  assign timeout_flag = timeout_q;
  assign trigger      = trigger_q;

endmodule

// File: tb/tb_crypto_core_sequencer.sv
// Testbench for crypto_core_sequencer: behavioural cores plus a result scoreboard.
module tb_crypto_core_sequencer;

  localparam int unsigned NC  = 4;
  localparam int unsigned CTW = 128;
  localparam int unsigned DW  = 16;
  localparam int unsigned RW  = 8;
  localparam int unsigned CW  = 32;
  localparam int unsigned TO  = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [1:0]        core_sel;
  logic [DW-1:0]     trig_dly;
  logic [RW-1:0]     reps;
  logic [NC-1:0]     core_busy;
  logic [NC*CTW-1:0] core_ct;
  logic [NC-1:0]     core_start;
  logic [CTW-1:0]    ct_out;
  logic [CW-1:0]     cycles_out;
  logic              busy, done, done_pulse, timeout_flag, trigger;

  crypto_core_sequencer #(
    .NUM_CORES(NC), .CT_WIDTH(CTW), .DLY_W(DW), .REP_W(RW), .CYC_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .core_sel(core_sel), .trig_dly(trig_dly),
    .reps(reps), .core_busy(core_busy), .core_ct(core_ct), .core_start(core_start),
    .ct_out(ct_out), .cycles_out(cycles_out), .busy(busy), .done(done),
    .done_pulse(done_pulse), .timeout_flag(timeout_flag), .trigger(trigger)
  );

  always #5 clk = ~clk;

  // Behavioural cores: busy for busy_len cycles after their launch pulse
  int        busy_len [NC];
  int        busy_cnt [NC];
  logic [NC-1:0] stuck;

  always @(posedge clk) begin
    for (int i = 0; i < int'(NC); i++) begin
      if (core_start[i])        busy_cnt[i] <= busy_len[i];
      else if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NC); i++) core_busy[i] = stuck[i] | (busy_cnt[i] != 0);
  end

  typedef struct {
    logic [CTW-1:0] ct;
    logic [CW-1:0]  cyc;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             errors = 0;
  logic [CTW-1:0] last_ct = '0;

  function automatic logic [CTW-1:0] ct_of(input int i);
    logic [CTW-1:0] v;
    if (i == 2) v = {4{32'hDEADBEEF}};
    else        v = {4{32'h1000_0000 + 32'(i) * 32'h0101_0101}};
    return v;
  endfunction

  // Drive a start edge; expectation pushed for cores that will complete
  task automatic launch(input int sel, input int dly, input int rp);
    exp_t e;
    @(negedge clk);
    core_sel = 2'(sel);
    trig_dly = DW'(dly);
    reps     = RW'(rp);
    start    = 1'b1;
    if (!stuck[sel]) begin
      e.ct  = ct_of(sel);
      e.cyc = (busy_len[sel] > 0) ? CW'(busy_len[sel] + 1) : CW'(2);
      sb.push_back(e);
    end
  endtask

  // Run until done_pulse or budget; start is released after the first sample if drop=1
  task automatic run_to_done(input int budget, input bit drop, output int n_start,
                             output int first_k, output logic [NC-1:0] start_vec,
                             output bit got);
    n_start = 0; first_k = -1; start_vec = '0; got = 1'b0;
    for (int k = 1; k <= budget && !got; k++) begin
      @(negedge clk);
      if (|core_start) begin
        n_start++;
        start_vec = start_vec | core_start;
        if (first_k < 0) first_k = k;
      end
      if (done_pulse) got = 1'b1;
      if (drop) start = 1'b0;
    end
  endtask

  task automatic check_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (ct_out !== e.ct) begin
        errors++;
        $display("FAIL %s ct_out got %h want %h", name, ct_out, e.ct);
      end
      checks++;
      if (cycles_out !== e.cyc) begin
        errors++;
        $display("FAIL %s cycles_out got %0d want %0d", name, cycles_out, e.cyc);
      end
      last_ct = e.ct;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({core_start, busy, done, done_pulse, timeout_flag, trigger} !== {4'b0, 5'b01000}) begin
      errors++;
      $display("FAIL reset_status got cs=%b busy=%b done=%b dp=%b to=%b trig=%b want 0,0,1,0,0,0",
               core_start, busy, done, done_pulse, timeout_flag, trigger);
    end
    checks++;
    if (ct_out !== '0 || cycles_out !== '0) begin
      errors++;
      $display("FAIL reset_data got ct=%h cyc=%0d want 0", ct_out, cycles_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n, fk; logic [NC-1:0] sv; bit got;
    busy_len[2] = 10;
    launch(2, 0, 0);
    run_to_done(60, 1'b1, n, fk, sv, got);
    checks++;
    if (!got || n != 1 || fk != 1 || sv !== 4'b0100) begin
      errors++;
      $display("FAIL single_launch got done=%0d starts=%0d first=%0d vec=%b want 1,1,1,0100",
               got, n, fk, sv);
    end
    check_result("single");
    @(negedge clk);
    checks++;
    if (done_pulse !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse_width got dp=%b done=%b want 0,1", done_pulse, done);
    end
  endtask

  task automatic test_reps();
    int launches[$]; int n_dp = 0; int low_run = 0; int gaps[$];
    bit in_op = 1'b0;
    busy_len[1] = 3;
    launch(1, 5, 3);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (|core_start) begin
        if (launches.size() > 0) gaps.push_back(low_run);
        launches.push_back(k);
        in_op = 1'b1;
      end
      if (in_op && !trigger) low_run++;
      if (trigger) low_run = 0;
      if (done_pulse) begin
        n_dp++;
        if (n_dp == 1) check_result("reps");
      end
    end
    checks++;
    if (launches.size() != 4 || n_dp != 1) begin
      errors++;
      $display("FAIL reps_count got launches=%0d done_pulses=%0d want 4,1", launches.size(), n_dp);
    end
    if (launches.size() == 4) begin
      checks++;
      if (launches[0] != 6 || launches[1] - launches[0] != 11 || launches[3] - launches[2] != 11) begin
        errors++;
        $display("FAIL reps_timing got %0d,%0d,%0d,%0d want 6,17,28,39",
                 launches[0], launches[1], launches[2], launches[3]);
      end
      checks++;
      if (gaps[0] != 6 || gaps[1] != 6 || gaps[2] != 6) begin
        errors++;
        $display("FAIL reps_trigger_gap got %0d,%0d,%0d want 6,6,6", gaps[0], gaps[1], gaps[2]);
      end
    end
  endtask

  task automatic test_no_busy();
    int n, fk; logic [NC-1:0] sv; bit got;
    busy_len[3] = 0;
    launch(3, 2, 0);
    run_to_done(40, 1'b1, n, fk, sv, got);
    checks++;
    if (!got || n != 1 || fk != 3 || sv !== 4'b1000) begin
      errors++;
      $display("FAIL nobusy_launch got done=%0d starts=%0d first=%0d vec=%b want 1,1,3,1000",
               got, n, fk, sv);
    end
    check_result("nobusy");
  endtask

  task automatic test_timeout();
    int first_to = -1; bit busy_at = 1'b1; int n_dp = 0;
    int n, fk; logic [NC-1:0] sv; bit got;
    stuck[1] = 1'b1;
    launch(1, 0, 2);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_pulse) n_dp++;
      if (timeout_flag && first_to < 0) begin
        first_to = k;
        busy_at  = busy;
      end
    end
    checks++;
    if (first_to != 66 || busy_at !== 1'b0 || n_dp != 0) begin
      errors++;
      $display("FAIL timeout_abort got at=%0d busy=%b dp=%0d want 66,0,0", first_to, busy_at, n_dp);
    end
    checks++;
    if (ct_out !== last_ct || timeout_flag !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold got ct=%h flag=%b want %h,1", ct_out, timeout_flag, last_ct);
    end
    stuck[1]    = 1'b0;
    busy_len[1] = 4;
    launch(1, 0, 0);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got %b want 0", timeout_flag);
    end
    run_to_done(40, 1'b1, n, fk, sv, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout_rerun got no done_pulse want done_pulse");
    end else begin
      check_result("after_timeout");
    end
  endtask

  task automatic test_start_ignored();
    int n = 0; int n2, fk; logic [NC-1:0] sv; bit got = 1'b0;
    busy_len[0] = 8;
    launch(0, 0, 0);
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (|core_start) n++;
      if (done_pulse) got = 1'b1;
      if (k == 4 || k == 6) start = 1'b0;
      if (k == 5 || k == 7) start = 1'b1;
    end
    checks++;
    if (!got || n != 1) begin
      errors++;
      $display("FAIL toggle_ignored got done=%0d starts=%0d want 1,1", got, n);
    end
    if (got) check_result("toggle");
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (|core_start || busy) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL held_start got %0d active cycles want 0", n);
    end
    start = 1'b0;
    launch(0, 0, 0);
    run_to_done(40, 1'b1, n2, fk, sv, got);
    checks++;
    if (!got || n2 != 1) begin
      errors++;
      $display("FAIL restart got done=%0d starts=%0d want 1,1", got, n2);
    end
    if (got) check_result("restart");
  endtask

  task automatic test_mid_reset();
    int n = 0; int n2, fk; logic [NC-1:0] sv; bit got;
    busy_len[0] = 30;
    launch(0, 2, 0);
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (trigger !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_running got trig=%b busy=%b want 1,1", trigger, busy);
    end
    void'(sb.pop_back());
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (core_start !== '0 || busy !== 1'b0 || done !== 1'b1 || trigger !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got cs=%b busy=%b done=%b trig=%b want 0,0,1,0",
               core_start, busy, done, trigger);
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (|core_start || busy) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL midreset_quiet got %0d active cycles want 0", n);
    end
    busy_len[0] = 5;
    launch(0, 1, 0);
    run_to_done(40, 1'b1, n2, fk, sv, got);
    checks++;
    if (!got || n2 != 1 || fk != 2) begin
      errors++;
      $display("FAIL midreset_rerun got done=%0d starts=%0d first=%0d want 1,1,2", got, n2, fk);
    end
    if (got) check_result("midreset_rerun");
  endtask

  initial begin
    start = 1'b0; core_sel = '0; trig_dly = '0; reps = '0; stuck = '0;
    for (int i = 0; i < int'(NC); i++) begin
      busy_len[i] = 5;
      busy_cnt[i] = 0;
      core_ct[i*CTW +: CTW] = ct_of(i);
    end
    test_reset();
    test_single();
    test_reps();
    test_no_busy();
    test_timeout();
    test_start_ignored();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
